noc_flit_packetizer: RTL and testbench
======================================

NOC_FLIT_PACKETIZER -- requirements
Module: noc_flit_packetizer

Interface
REQ-001 SHALL have parameter NUM_BITS, default 32, flit width (only 32 supported).
REQ-002 SHALL have parameter SRC_ID, default 8'd0, source node id placed in head flit bits [7:0].
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-high reset (asserted = 1 despite the name).
REQ-005 SHALL have port pkt_valid, input, 1, packet request present.
REQ-006 SHALL have port pkt_dst, input, 8, destination node id.
REQ-007 SHALL have port pkt_len, input, 8, payload word count.
REQ-008 SHALL have port pkt_ready, output, 1, packet request accepted this cycle when high with pkt_valid.
REQ-009 SHALL have port pay_valid, input, 1, payload word present.
REQ-010 SHALL have port pay_data, input, 30, payload word.
REQ-011 SHALL have port pay_ready, output, 1, payload word consumed when high with pay_valid.
REQ-012 SHALL have port fifo_full, input, 1, downstream fifo full.
REQ-013 SHALL have port wr_en, output, 1, downstream fifo write strobe.
REQ-014 SHALL have port fifo_in, output, NUM_BITS, flit to downstream fifo.
REQ-015 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-016 Flit type in [31:30]: 01 head, 10 body, 11 tail; 00 never written.
REQ-017 Head flit: [31:30]=01, [29:24]=sequence field, [23:16]=effective length, [15:8]=dst, [7:0]=SRC_ID.
REQ-018 Body/tail flit: type in [31:30], pay_data in [29:0].
REQ-019 FSM states IDLE, HEAD, PAYLOAD; IDLE->HEAD on pkt_valid&&pkt_ready; HEAD->PAYLOAD on head write; PAYLOAD->IDLE on tail write.
REQ-020 pkt_ready SHALL equal (state==IDLE); dst and effective length latched on acceptance.
REQ-021 Effective length SHALL be pkt_len, except pkt_len==0 becomes 1.
REQ-022 In HEAD, wr_en=!fifo_full with fifo_in=head flit; state holds while fifo_full.
REQ-023 In PAYLOAD, pay_ready=!fifo_full and wr_en=pay_valid&&!fifo_full, combinational, same cycle.
REQ-024 Remaining counter loads effective length, decrements per payload write; write with remaining==1 is tail, else body.
REQ-025 pay_ready SHALL be 0 and wr_en SHALL be 0 outside the cases above; fifo_in SHALL be 0 when wr_en=0.
REQ-026 wr_en SHALL never be high while fifo_full is high.
REQ-027 Exactly 1+effective length flits per packet; minimum packet is head+tail, 2 flits, no body.
REQ-028 Back-to-back: new packet accepted the cycle after tail write (IDLE for exactly one cycle).

Reset
REQ-029 rst_n high SHALL asynchronously force IDLE, remaining=0, sequence=0; wr_en, pay_ready, busy=0, pkt_ready=1 while reset is held.
REQ-030 Reset mid-packet SHALL abandon the packet with no tail written; first write after release is a head.

Configuration
REQ-031 With macro PKT_SEQ_EN defined: head [29:24] = 6-bit sequence counter, incremented after each head write, wrap 63->0.
REQ-032 Without PKT_SEQ_EN: head [29:24]=0, no sequence counter present.

Verification
REQ-033 pkt_dst=8'h05, pkt_len=3, SRC_ID=8'h02, fifo_full=0, pay_valid held high -> 4 consecutive wr_en cycles: 32'h4003_0502, body, body, tail (type 11).
REQ-034 pkt_len=0 -> head with [23:16]=1, then exactly one tail flit, then IDLE.
REQ-035 fifo_full high 3 cycles during HEAD and mid-PAYLOAD -> wr_en and pay_ready low those cycles, no flit lost or duplicated.
REQ-036 rst_n pulsed after 2 of 5 payload flits -> no tail; next packet starts with head, sequence field 0.
REQ-037 PKT_SEQ_EN defined, 65 single-word packets -> head [29:24] sequence 0..63, 0; undefined -> always 0.

Source files
------------

// File: rtl/noc_flit_packetizer.sv
// Packetizer: turns a packet request plus payload words into head/body/tail flits for a downstream FIFO.
// Optional macro PKT_SEQ_EN enables a 6-bit head sequence counter in head bits [29:24].
module noc_flit_packetizer #(
    parameter int         NUM_BITS = 32,
    parameter logic [7:0] SRC_ID   = 8'd0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pkt_valid,
    input  logic [7:0]          pkt_dst,
    input  logic [7:0]          pkt_len,
    output logic                pkt_ready,
    input  logic                pay_valid,
    input  logic [29:0]         pay_data,
    output logic                pay_ready,
    input  logic                fifo_full,
    output logic                wr_en,
    output logic [NUM_BITS-1:0] fifo_in,
    output logic                busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEAD    = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [7:0]          dst_q, dst_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          rem_q, rem_d;
    logic [5:0]          seq_field;
    logic [NUM_BITS-1:0] flit;

`ifdef PKT_SEQ_EN
    logic [5:0] seq_q, seq_d;
    assign seq_field = seq_q;
`else
    assign seq_field = '0;
`endif

    always_comb begin
        state_d   = state_q;
        dst_d     = dst_q;
        len_d     = len_q;
        rem_d     = rem_q;
        pkt_ready = 1'b0;
        pay_ready = 1'b0;
        wr_en     = 1'b0;
        flit      = '0;
`ifdef PKT_SEQ_EN
        seq_d     = seq_q;
`endif
        case (state_q)
            ST_IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    // Zero-length requests still carry one payload word (the tail).
                    state_d = ST_HEAD;
                    dst_d   = pkt_dst;
                    len_d   = (pkt_len == 8'd0) ? 8'd1 : pkt_len;
                    rem_d   = (pkt_len == 8'd0) ? 8'd1 : pkt_len;
                end
            end
            ST_HEAD: begin
                if (!fifo_full) begin
                    wr_en   = 1'b1;
                    flit    = {2'b01, seq_field, len_q, dst_q, SRC_ID};
                    state_d = ST_PAYLOAD;
`ifdef PKT_SEQ_EN
                    seq_d   = seq_q + 6'd1;
`endif
                end
            end
            ST_PAYLOAD: begin
                pay_ready = !fifo_full;
                if (pay_valid && !fifo_full) begin
                    wr_en = 1'b1;
                    flit  = {((rem_q == 8'd1) ? 2'b11 : 2'b10), pay_data};
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fifo_in = flit;
    assign busy    = (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            dst_q   <= '0;
            len_q   <= '0;
            rem_q   <= '0;
`ifdef PKT_SEQ_EN
            seq_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
`ifdef PKT_SEQ_EN
            seq_q   <= seq_d;
`endif
        end
    end

endmodule

// File: tb/tb_noc_flit_packetizer.sv
// Scoreboard bench for noc_flit_packetizer: table of packet vectors plus reset-abort and sequence-wrap sequences.
module tb_noc_flit_packetizer;

    localparam logic [7:0] SRC = 8'h02;
`ifdef PKT_SEQ_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        pkt_valid;
    logic [7:0]  pkt_dst;
    logic [7:0]  pkt_len;
    logic        pkt_ready;
    logic        pay_valid;
    logic [29:0] pay_data;
    logic        pay_ready;
    logic        fifo_full;
    logic        wr_en;
    logic [31:0] fifo_in;
    logic        busy;

    noc_flit_packetizer #(.NUM_BITS(32), .SRC_ID(SRC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pkt_valid (pkt_valid),
        .pkt_dst   (pkt_dst),
        .pkt_len   (pkt_len),
        .pkt_ready (pkt_ready),
        .pay_valid (pay_valid),
        .pay_data  (pay_data),
        .pay_ready (pay_ready),
        .fifo_full (fifo_full),
        .wr_en     (wr_en),
        .fifo_in   (fifo_in),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0]  dst;
        logic [7:0]  len;
        int          stall_head;
        int          stall_at;
        int          stall_len;
        logic [31:0] head;   // expected head flit with sequence field zero
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] exp_q[$];
    int          wr_log[$];
    logic [29:0] pdata[256];
    logic [5:0]  exp_seq;
    int          n_cmp;
    int          n_fail;
    int          cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en) begin
            chk("wr_while_full", {31'd0, fifo_full}, 32'd0);
            wr_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_flit: got %h expected none", fifo_in);
            end else begin
                chk("flit", fifo_in, exp_q.pop_front());
            end
        end else begin
            chk("fifo_in_zero_when_idle", fifo_in, 32'd0);
        end
    end

    task automatic reset_checks();
        chk("rst_pkt_ready", {31'd0, pkt_ready}, 32'd1);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_wr_en",     {31'd0, wr_en},     32'd0);
        chk("rst_pay_ready", {31'd0, pay_ready}, 32'd0);
    endtask

    task automatic pulse_reset();
        pay_valid = 1'b0;
        pkt_valid = 1'b0;
        fifo_full = 1'b0;
        rst_n     = 1'b1;
        #1;
        reset_checks();
        exp_q.delete();
        exp_seq = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
    endtask

    // Called and returns at posedge+1.
    task automatic run_pkt(input logic [7:0] dst, input logic [7:0] len, input logic [31:0] head0,
                           input int sh, input int mat, input int mlen, input int abort_after);
        int   eff;
        int   guard;
        int   k;
        int   c;
        logic took;
        eff = (len == 8'd0) ? 1 : int'(len);
        for (int i = 0; i < eff; i++) pdata[i] = 30'($urandom);
        exp_q.push_back(head0 | {2'b00, exp_seq, 24'd0});
        if (SEQ_EN) exp_seq = exp_seq + 6'd1;
        for (int i = 0; i < eff; i++)
            exp_q.push_back({((i == eff - 1) ? 2'b11 : 2'b10), pdata[i]});

        pkt_valid = 1'b1;
        pkt_dst   = dst;
        pkt_len   = len;
        guard = 0;
        while (!pkt_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!pkt_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            pkt_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        pkt_dst   = 8'($urandom);
        pkt_len   = 8'($urandom);
        chk("busy_in_head", {31'd0, busy}, 32'd1);
        chk("pkt_ready_in_head", {31'd0, pkt_ready}, 32'd0);

        fifo_full = (sh > 0);
        repeat (sh) begin
            @(posedge clk); #1;
        end
        fifo_full = 1'b0;
        @(posedge clk); #1;

        k = 0;
        c = 0;
        while (k < eff && c < 2000) begin
            if (abort_after >= 0 && k == abort_after) begin
                pulse_reset();
                return;
            end
            pay_valid = 1'b1;
            pay_data  = pdata[k];
            fifo_full = (c >= mat && c < mat + mlen);
            #1;
            took = pay_ready;
            chk("pay_ready", {31'd0, pay_ready}, {31'd0, ~fifo_full});
            @(posedge clk); #1;
            if (took) k++;
            c++;
        end
        pay_valid = 1'b0;
        fifo_full = 1'b0;
        if (c >= 2000) chk("payload_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        cyc       = 0;
        exp_seq   = '0;
        rst_n     = 1'b1;
        pkt_valid = 1'b0;
        pkt_dst   = '0;
        pkt_len   = '0;
        pay_valid = 1'b0;
        pay_data  = '0;
        fifo_full = 1'b0;

        vecs[0] = '{8'h05, 8'd3,   0, 0, 0, 32'h4003_0502};
        vecs[1] = '{8'h0A, 8'd0,   0, 0, 0, 32'h4001_0A02};
        vecs[2] = '{8'hFF, 8'd1,   3, 0, 0, 32'h4001_FF02};
        vecs[3] = '{8'h33, 8'd4,   0, 2, 3, 32'h4004_3302};
        vecs[4] = '{8'h00, 8'd2,   3, 1, 3, 32'h4002_0002};
        vecs[5] = '{8'h81, 8'd255, 0, 0, 0, 32'h40FF_8102};

        repeat (2) @(posedge clk);
        #1;
        reset_checks();
        chk("rst_fifo_in", fifo_in, 32'd0);
        rst_n = 1'b0;

        for (int i = 0; i < 6; i++) begin
            int eff;
            eff = (vecs[i].len == 8'd0) ? 1 : int'(vecs[i].len);
            wr_log.delete();
            run_pkt(vecs[i].dst, vecs[i].len, vecs[i].head, vecs[i].stall_head,
                    vecs[i].stall_at, vecs[i].stall_len, -1);
            chk("idle_after_tail", {31'd0, pkt_ready}, 32'd1);
            chk("busy_after_tail", {31'd0, busy}, 32'd0);
            chk("writes_per_pkt", 32'(wr_log.size()), 32'(eff + 1));
            if (vecs[i].stall_head == 0 && vecs[i].stall_len == 0 && wr_log.size() > 0)
                chk("consecutive_writes", 32'(wr_log[wr_log.size() - 1] - wr_log[0]), 32'(eff));
        end

        // Reset after 2 of 5 payload words: no tail, next head carries sequence 0.
        wr_log.delete();
        run_pkt(8'h12, 8'd5, 32'h4005_1202, 0, 0, 0, 2);
        chk("abort_writes", 32'(wr_log.size()), 32'd3);
        run_pkt(8'h21, 8'd2, 32'h4002_2102, 0, 0, 0, -1);

        // 65 single-word packets starting from a fresh reset exercise the sequence wrap.
        pulse_reset();
        for (int i = 0; i < 65; i++)
            run_pkt(8'(i), 8'd1, 32'h4001_0002 | (32'(i) << 8), 0, 0, 0, -1);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
